// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready input handshake, flag outputs,
// an illegal-opcode error flag and a multi-cycle unsigned shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic             err,
  output logic             out_valid
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_SRA = 4'h8,
    OP_CMP = 4'h9,
    OP_INC = 4'hA,
    OP_MUL = 4'hB
  } op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e state, state_nxt;

  logic               accept;
  logic               accept_mul;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] mul_next;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH:0]     add_res;
  logic [WIDTH:0]     sub_res;
  logic               add_v;
  logic               sub_v;

  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_c;
  logic               alu_v;
  logic               alu_z;
  logic               alu_n;
  logic               alu_hold;
  logic               alu_err;

  assign accept     = in_valid && in_ready;
  assign accept_mul = accept && (sel == OP_MUL);
  assign mul_last   = (cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake: only IDLE accepts; MUL ends when the counter expires
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (sel == OP_MUL)) state_nxt = S_MUL;
      end
      S_MUL: begin
        if (mul_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ALU: result, flag source value and arithmetic flags
  always_comb begin
    add_b    = (sel == OP_INC) ? WIDTH'(1) : B;
    add_res  = {1'b0, A} + {1'b0, add_b};
    sub_res  = {1'b0, A} - {1'b0, B};
    add_v    = (A[MSB] == add_b[MSB]) && (add_res[MSB] != A[MSB]);
    sub_v    = (A[MSB] != B[MSB]) && (sub_res[MSB] != A[MSB]);
    alu_y    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_hold = 1'b0;
    alu_err  = 1'b0;
    case (sel)
      OP_ADD, OP_INC: begin
        alu_y = add_res[WIDTH-1:0];
        alu_c = add_res[WIDTH];
        alu_v = add_v;
      end
      OP_SUB, OP_CMP: begin
        alu_y    = sub_res[WIDTH-1:0];
        alu_c    = sub_res[WIDTH];
        alu_v    = sub_v;
        alu_hold = (sel == OP_CMP);
      end
      OP_AND: alu_y = A & B;
      OP_OR:  alu_y = A | B;
      OP_XOR: alu_y = A ^ B;
      OP_NOT: alu_y = ~A;
      OP_SHL: begin
        alu_y = {A[WIDTH-2:0], 1'b0};
        alu_c = A[MSB];
      end
      OP_SHR: begin
        alu_y = {1'b0, A[WIDTH-1:1]};
        alu_c = A[0];
      end
      OP_SRA: begin
        alu_y = {A[MSB], A[WIDTH-1:1]};
        alu_c = A[0];
      end
      OP_MUL: alu_y = '0;
      default: alu_err = 1'b1;
    endcase
    // CMP keeps Y but still derives zero/negative from the difference
    alu_f = alu_y;
    alu_z = (alu_f == '0) && !alu_err;
    alu_n = alu_f[MSB];
  end

  // One shift-add iteration: conditionally add multiplicand to the high half, shift right
  always_comb begin
    mul_add  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_add, prod[WIDTH-1:1]};
  end

  // Result/flag registers, multiplier datapath and the out_valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      Y         <= '0;
      Y_hi      <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept_mul) begin
        mcand <= A;
        prod  <= {{WIDTH{1'b0}}, B};
        cnt   <= CW'(WIDTH);
      end else if (accept) begin
        if (!alu_hold) Y <= alu_y;
        Y_hi      <= '0;
        carry_out <= alu_c;
        zero      <= alu_z;
        overflow  <= alu_v;
        negative  <= alu_n;
        err       <= alu_err;
        out_valid <= 1'b1;
      end else if (state == S_MUL) begin
        prod <= mul_next;
        cnt  <= cnt - CW'(1);
        if (mul_last) begin
          Y         <= mul_next[WIDTH-1:0];
          Y_hi      <= mul_next[2*WIDTH-1:WIDTH];
          carry_out <= (mul_next[2*WIDTH-1:WIDTH] != '0);
          overflow  <= (mul_next[2*WIDTH-1:WIDTH] != '0);
          zero      <= (mul_next == '0);
          negative  <= 1'b0;
          err       <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8 main instance, WIDTH=16 multiply check).
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = '0, B = '0;
  logic [3:0] sel = '0;
  logic [7:0] Y, Y_hi;
  logic       carry_out, zero, overflow, negative, err, out_valid;

  logic        v16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  s16 = '0;
  logic        rdy16;
  logic [15:0] y16, yh16;
  logic        c16, z16, ov16, n16, e16, ovld16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] y;
    logic [7:0] yhi;
    logic [4:0] f;   // {carry, zero, overflow, negative, err}
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_last_y = '0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .Y(Y), .Y_hi(Y_hi),
    .carry_out(carry_out), .zero(zero), .overflow(overflow),
    .negative(negative), .err(err), .out_valid(out_valid)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .A(a16), .B(b16), .sel(s16), .Y(y16), .Y_hi(yh16),
    .carry_out(c16), .zero(z16), .overflow(ov16),
    .negative(n16), .err(e16), .out_valid(ovld16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] s, input logic [7:0] prev);
    exp_t x;
    int ua, ub, sa, sb_, r, rs, p;
    logic [7:0] fv;
    logic c, v, z, n, e;
    ua = a; ub = b; sa = $signed(a); sb_ = $signed(b);
    c = 1'b0; v = 1'b0; e = 1'b0; fv = '0;
    x.y = '0; x.yhi = '0; x.cyc = 0;
    case (s)
      4'h0, 4'hA: begin
        if (s == 4'hA) begin ub = 1; sb_ = 1; end
        r = ua + ub; rs = sa + sb_;
        fv = r[7:0]; c = (r > 255); v = (rs > 127) || (rs < -128);
      end
      4'h1, 4'h9: begin
        r = ua - ub; rs = sa - sb_;
        fv = r[7:0]; c = (ua < ub); v = (rs > 127) || (rs < -128);
      end
      4'h2: fv = a & b;
      4'h3: fv = a | b;
      4'h4: fv = a ^ b;
      4'h5: fv = ~a;
      4'h6: begin fv = 8'(a << 1); c = a[7]; end
      4'h7: begin fv = a >> 1; c = a[0]; end
      4'h8: begin fv = 8'($signed(a) >>> 1); c = a[0]; end
      default: ;
    endcase
    z = (fv == 8'h00);
    n = fv[7];
    x.y = (s == 4'h9) ? prev : fv;
    if (s == 4'hB) begin
      p = ua * ub;
      x.y = p[7:0]; x.yhi = p[15:8];
      c = (p > 255); v = c; z = (p == 0); n = 1'b0;
    end else if (s >= 4'hC) begin
      x.y = '0; c = 1'b0; v = 1'b0; z = 1'b0; n = 1'b0; e = 1'b1;
    end
    x.f = {c, z, v, n, e};
    return x;
  endfunction

  // Drive an op (called #1 after a rising edge), wait for acceptance, push its expectation
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    exp_t x;
    int n;
    A = a; B = b; sel = s; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    x = model(a, b, s, exp_last_y);
    x.cyc = cyc + 1 + ((s == 4'hB) ? 8 : 0);
    exp_last_y = x.y;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("Y", 32'(Y), 32'(x.y));
        check("Y_hi", 32'(Y_hi), 32'(x.yhi));
        check("flags_CZVNE", 32'({carry_out, zero, overflow, negative, err}), 32'(x.f));
        check("latency", 32'(cyc), 32'(x.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset with in_valid held high: must be ignored
    in_valid = 1'b1; sel = 4'h0; A = 8'h01; B = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_Y", 32'(Y), 32'd0);
    check("rst_flags", 32'({carry_out, zero, overflow, negative, err, out_valid}), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Arithmetic basics
    issue(8'h12, 8'h34, 4'h0); idle(2);
    issue(8'h80, 8'h80, 4'h0); idle(1);
    issue(8'h11, 8'h55, 4'h1); idle(1);
    issue(8'h55, 8'h55, 4'h9); idle(1);
    issue(8'h80, 8'h00, 4'h8); idle(1);
    issue(8'h81, 8'h00, 4'h6);
    issue(8'h01, 8'h00, 4'h7);
    issue(8'h0F, 8'h00, 4'h5);
    issue(8'h7F, 8'h00, 4'hA);
    issue(8'hFF, 8'h00, 4'hA);
    issue(8'h7F, 8'h80, 4'h1);
    idle(2);

    // Back-to-back logic ops ending in an illegal opcode
    issue(8'hF0, 8'h0F, 4'h2);
    issue(8'hF0, 8'h0F, 4'h3);
    issue(8'hAA, 8'hFF, 4'h4);
    issue(8'h00, 8'h00, 4'hF);
    idle(2);

    // MUL FF*FF with a competing ADD held during the busy window
    issue(8'hFF, 8'hFF, 4'hB);
    A = 8'h01; B = 8'h01; sel = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("mul_done_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    idle(1);

    // MUL then a queued ADD accepted in the completion cycle
    issue(8'h03, 8'h05, 4'hB);
    issue(8'h01, 8'h01, 4'h0);
    idle(2);
    issue(8'h00, 8'h55, 4'hB);
    idle(2);

    // Reset three cycles into a MUL: no result, outputs cleared
    issue(8'h0A, 8'h0B, 4'hB);
    idle(3);
    rst = 1'b1;
    sb.delete();
    exp_last_y = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mulrst_Y", 32'({Y, Y_hi}), 32'd0);
    check("mulrst_flags", 32'({carry_out, zero, overflow, negative, err, out_valid}), 32'd0);
    check("mulrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    idle(12);

    // Random mix through the scoreboard
    for (int i = 0; i < 40; i++)
      issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    idle(12);

    // WIDTH=16 multiply
    a16 = 16'h1234; b16 = 16'h0100; s16 = 4'hB; v16 = 1'b1;
    @(negedge clk);
    check("w16_in_ready", 32'(rdy16), 32'd1);
    @(posedge clk); #1;
    v16 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ovld16 && n < 40);
    check("w16_latency", 32'(n), 32'd17);
    check("w16_Y", 32'(y16), 32'h3400);
    check("w16_Y_hi", 32'(yh16), 32'h0012);
    check("w16_flags_CZVNE", 32'({c16, z16, ov16, n16, e16}), 32'b10100);
    @(posedge clk); #1;
    @(negedge clk);
    check("w16_pulse_once", 32'(ovld16), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 8-bit ALU. It adds:
- a valid/ready input handshake and registered results with a one-cycle `out_valid` pulse;
- a negative flag and an error flag for illegal opcodes;
- a multi-cycle unsigned shift-add multiplier that produces a double-width product.

It sits between the datapath sequencer and the register file. Single-cycle ops sustain one result per clock. MUL stalls the input for WIDTH cycles.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 4..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands/opcode valid.
- `in_ready`  out  1  block can accept; transfer occurs when `in_valid & in_ready` at a rising edge.
- `A`, `B`  in  WIDTH  operands.
- `sel`  in  4  opcode.
- `Y`  out  WIDTH  result, or low half of the product.
- `Y_hi`  out  WIDTH  high half of the product; 0 for all non-MUL ops.
- `carry_out`, `zero`, `overflow`, `negative`, `err`  out  1 each  registered flags.
- `out_valid`  out  1  one-cycle pulse: new result and flags are present.

## Operation
- **Opcodes:**
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT A
  - 0110 SHL by 1
  - 0111 SHR logical by 1
  - 1000 SRA by 1
  - 1001 CMP
  - 1010 INC A
  - 1011 MUL (unsigned)
  - 1100–1111 illegal
- **Flags, all ops:** `negative` = Y[WIDTH-1]; `zero` = (Y==0).
- **ADD / INC:** `carry_out` = bit WIDTH of the (WIDTH+1)-bit sum. `overflow` = signed overflow (operands have the same sign and the result sign differs).
- **SUB / CMP:** `carry_out` = borrow (A<B unsigned). `overflow` = signed subtraction overflow.
- **CMP:** computes flags exactly as SUB, but Y holds its previous value. `zero`/`negative` are taken from the difference, not from Y.
- **Logic ops and NOT:** `carry_out` = 0, `overflow` = 0.
- **Shifts:**
  - SHL: `carry_out` = A[WIDTH-1].
  - SHR and SRA: `carry_out` = A[0].
  - SRA replicates A[WIDTH-1].
  - `overflow` = 0 for all shifts.
- **MUL:**
  - {Y_hi, Y} = A×B, 2·WIDTH bits.
  - `carry_out` = `overflow` = (Y_hi≠0).
  - `zero` = (full product == 0).
  - `negative` = 0.
- **Illegal opcode:** result completes in one cycle. Y = Y_hi = 0, all arithmetic flags 0, `err` = 1.
- `err` = 0 for every legal result. All outputs hold until the next result or reset.
- **FSM:**
  - IDLE: `in_ready` = 1.
    - Accepted non-MUL op: result registered on the same edge; stay in IDLE.
    - Accepted MUL: load multiplicand, multiplier and accumulator; counter = WIDTH; go to MUL.
  - MUL: `in_ready` = 0; `in_valid` is ignored.
    - Each edge performs one shift-add iteration and decrements the counter.
    - On the edge where the counter reaches 0: write Y/Y_hi/flags, pulse `out_valid`, go to IDLE.

## Timing
- **Reset values:** Y = 0, Y_hi = 0, all flags 0, `err` = 0, `out_valid` = 0, state IDLE.
- `in_valid` is ignored during any cycle with `rst` high. `in_ready` = 1 in the first cycle after reset deassertion.
- **Non-MUL latency:** operands accepted at edge k → `out_valid` high in cycle k+1. Back-to-back acceptance every cycle gives consecutive `out_valid` pulses.
- **MUL latency:**
  - Accepted at edge k → `in_ready` low during cycles k+1..k+WIDTH.
  - `out_valid` high in cycle k+WIDTH+1 (WIDTH+1 cycles after acceptance).
  - `in_ready` returns high in that same cycle, so a new op can be accepted at edge k+WIDTH+1.
- `out_valid` is never high for two cycles from one accepted op.
- **Reset during MUL:** the operation is abandoned. No `out_valid` is produced; outputs take reset values on the reset edge.
- Operand and opcode changes while busy have no effect. Operands are captured only at acceptance.

## Test plan
1. WIDTH=8, ADD 0x12+0x34 → Y=0x46, C=0, Z=0, V=0, N=0, `out_valid` in the next cycle only. ADD 0x80+0x80 → Y=0x00, C=1, Z=1, V=1.
2. SUB 0x11−0x55 → Y=0xBC, C=1 (borrow), N=1, V=0. CMP 0x55,0x55 → Z=1 and Y unchanged (0xBC). SRA 0x80 → Y=0xC0, C=0, N=1.
3. Back-to-back, one per cycle: AND F0,0F; OR F0,0F; XOR AA,FF; sel=1111 → four consecutive `out_valid` pulses:
   - AND: Y=0x00, Z=1
   - OR: Y=0xFF, N=1
   - XOR: Y=0x55
   - illegal: Y=0, `err`=1
4. MUL 0xFF×0xFF → `in_ready` low 8 cycles; a competing `in_valid` ADD during busy is not executed. Result: Y=0x01, Y_hi=0xFE, C=V=1. `out_valid` 9 cycles after acceptance.
5. MUL 0x03×0x05 then a queued ADD 0x01+0x01 → Y=0x0F, Y_hi=0 first; ADD accepted in the completion cycle; Y=0x02 one cycle later.
6. `rst` asserted 3 cycles into MUL → no `out_valid`, all outputs 0, `in_ready`=1 after release. Repeat at WIDTH=16: MUL 0x1234×0x0100 → Y=0x3400, Y_hi=0x0012, `out_valid` 17 cycles after acceptance.
